// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for the shared-UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REQ   = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_ready;
  logic                         send_valid;
  logic [WORD_SIZE-1:0]         data_bits;
  logic [ID_W-1:0]              grant_id;
  logic                         busy;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, send_valid, data_bits, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, send_valid, data_bits, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter; a multi-word message keeps the
// grant until its last word or until the hold timeout expires.
module uart_tx_arbiter #(
  parameter  int WORD_SIZE    = 8,
  parameter  int NUM_REQ      = 4,
  parameter  int HOLD_TIMEOUT = 64,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [2:0] {ARB, LOAD, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      grant;
  logic                 lock;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 send;
  logic [WORD_SIZE-1:0] data_q;

  logic [ID_W-1:0]      win;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      sel;
  logic [WORD_SIZE-1:0] sel_data;
  logic                 sel_last;
  logic                 xfer;
  logic [ID_W-1:0]      next_ptr;

  // Descending scan so the candidate nearest to ptr is written last and wins.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req_valid[cand]) win = cand;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (bus.tx_ready) begin
      if (state == ARB && |bus.req_valid) bus.req_ready[win] = 1'b1;
      else if (state == HOLD)             bus.req_ready[grant] = bus.req_valid[grant];
    end
  end

  assign sel  = (state == ARB) ? win : grant;
  assign xfer = |(bus.req_valid & bus.req_ready);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel == ID_W'(i)) sel_data = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
  end

  assign sel_last = bus.req_last[sel];
  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      ptr      <= '0;
      grant    <= '0;
      lock     <= 1'b0;
      hold_cnt <= '0;
      send     <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state)
        ARB: if (xfer) begin
          data_q <= sel_data;
          grant  <= win;
          lock   <= !sel_last;
          send   <= 1'b1;
          state  <= LOAD;
        end
        LOAD: begin
          send  <= 1'b0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.tx_ready) state <= WAIT_DONE;
        WAIT_DONE: if (bus.tx_ready) begin
          if (!lock) begin
            ptr   <= next_ptr;
            state <= ARB;
          end else begin
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            data_q <= sel_data;
            lock   <= !sel_last;
            send   <= 1'b1;
            state  <= LOAD;
          end else if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
            lock  <= 1'b0;
            ptr   <= next_ptr;
            state <= ARB;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.send_valid = send;
  assign bus.data_bits  = data_q;
  assign bus.grant_id   = grant;
  assign bus.busy       = (state != ARB);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: requester queues, a 4-cycle-per-bit transmitter model and a
// serial receiver that decodes the tx line independently.
module tb_uart_tx_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int HT = 8;
  localparam int BC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.WORD_SIZE(W), .NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // transmitter model: 10-bit frame, BC cycles per bit, not reset by rst
  logic       tx_rdy = 1'b1;
  logic       tx     = 1'b1;
  logic [8:0] sh     = '0;
  int         tcyc   = 0;
  int         tbit   = 0;
  assign bus.tx_ready = tx_rdy;

  always @(posedge clk) begin
    if (tx_rdy && bus.send_valid) begin
      sh <= {1'b1, bus.data_bits};
      tx <= 1'b0; tx_rdy <= 1'b0; tcyc <= 0; tbit <= 0;
    end else if (!tx_rdy) begin
      if (tcyc == BC - 1) begin
        tcyc <= 0;
        if (tbit == 9) tx_rdy <= 1'b1;
        else begin tx <= sh[0]; sh <= sh >> 1; tbit <= tbit + 1; end
      end else tcyc <= tcyc + 1;
    end
  end

  // receiver: samples mid-bit, pushes -1 on a bad stop bit
  int         rx_t = -1;
  int         rx_j;
  logic [7:0] rx_b = '0;
  int         rx_q[$];
  always @(negedge clk) begin
    if (rx_t < 0) begin
      if (!tx) rx_t = 0;
    end else begin
      rx_t++;
      if (rx_t % BC == BC / 2) begin
        rx_j = rx_t / BC;
        if (rx_j >= 1 && rx_j <= 8) rx_b[rx_j-1] = tx;
        else if (rx_j == 9) begin
          rx_q.push_back(tx ? int'(rx_b) : -1);
          rx_t = -1;
        end
      end
    end
  end

  // requester model and transfer log
  logic [N-1:0]   rv = '0;
  logic [N-1:0]   rl = '0;
  logic [N*W-1:0] rd = '0;
  assign bus.req_valid = rv;
  assign bus.req_last  = rl;
  assign bus.req_data  = rd;

  logic [8:0]   wmem [N][16];
  int           whead [N];
  int           wtail [N];
  logic [N-1:0] hs;
  int acc_id[$], acc_dat[$], acc_cyc[$], sv_cyc[$], sv_dat[$], sv_gid[$];

  always begin
    @(negedge clk);
    hs = rst ? '0 : (bus.req_valid & bus.req_ready);
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        acc_id.push_back(i);
        acc_dat.push_back(int'(bus.req_data[i*W +: W]));
        acc_cyc.push_back(cyc);
      end
    if (bus.send_valid && !rst) begin
      sv_cyc.push_back(cyc);
      sv_dat.push_back(int'(bus.data_bits));
      sv_gid.push_back(int'(bus.grant_id));
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) whead[i]++;
      rv[i]         = (whead[i] != wtail[i]);
      rd[i*W +: W]  = wmem[i][whead[i] % 16][7:0];
      rl[i]         = wmem[i][whead[i] % 16][8];
    end
  end

  // protocol monitor
  logic sv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.send_valid) begin
      checks++;
      if (sv_prev || !tx_rdy) begin
        failures++;
        $display("FAIL send_valid_protocol prev=%0b tx_ready=%0b want prev=0 tx_ready=1", sv_prev, tx_rdy);
      end
    end
    if (bus.req_ready != '0) begin
      checks++;
      if (!$onehot(bus.req_ready)) begin
        failures++;
        $display("FAIL req_ready_onehot got=%b want one-hot", bus.req_ready);
      end
    end
    sv_prev = bus.send_valid;
  end

  task automatic push(input int i, input logic last, input logic [7:0] d);
    wmem[i][wtail[i] % 16] = {last, d};
    wtail[i]++;
  endtask

  task automatic clear_logs();
    acc_id.delete(); acc_dat.delete(); acc_cyc.delete();
    sv_cyc.delete(); sv_dat.delete(); sv_gid.delete(); rx_q.delete();
  endtask

  task automatic wait_acc(input int n);
    for (int k = 0; k < 2000 && acc_id.size() < n; k++) @(negedge clk);
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 2000 && rx_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000 && !(tx_rdy && !bus.busy && rx_t < 0); k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    wait_idle();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.send_valid !== 1'b0) begin failures++; $display("FAIL reset_send_valid got=%0b want=0", bus.send_valid); end
    if (bus.data_bits !== 8'h00) begin failures++; $display("FAIL reset_data_bits got=%h want=00", bus.data_bits); end
    if (bus.grant_id !== 2'd0)   begin failures++; $display("FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
    if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    if (bus.req_ready !== 4'b0)  begin failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.send_valid !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%0b send_valid=%0b want 0 0", bus.busy, bus.send_valid);
    end
  endtask

  task automatic test_single();
    clear_logs();
    push(0, 1'b1, 8'hA5);
    wait_acc(1);
    repeat (3) @(negedge clk);
    checks++;
    if (acc_id.size() != 1) begin
      failures++; $display("FAIL single_accept_count got=%0d want=1", acc_id.size());
    end else begin
      checks += 4;
      if (acc_id[0] != 0 || acc_dat[0] != 'hA5) begin failures++; $display("FAIL single_accept id=%0d data=%h want 0 a5", acc_id[0], acc_dat[0]); end
      if (sv_cyc.size() != 1) begin failures++; $display("FAIL single_send_count got=%0d want=1", sv_cyc.size()); end
      else begin
        if (sv_cyc[0] != acc_cyc[0] + 1) begin failures++; $display("FAIL single_send_latency got=%0d want=1", sv_cyc[0] - acc_cyc[0]); end
        if (sv_dat[0] != 'hA5 || sv_gid[0] != 0) begin failures++; $display("FAIL single_send data=%h gid=%0d want a5 0", sv_dat[0], sv_gid[0]); end
      end
    end
    wait_rx(1);
    checks++;
    if (rx_q.size() < 1 || rx_q[0] != 'hA5) begin
      failures++; $display("FAIL single_tx_frame got=%0d want=165", rx_q.size() ? rx_q[0] : -2);
    end
    // pointer moved past requester 0, so 1 must win a simultaneous request
    wait_idle(); clear_logs();
    push(0, 1'b1, 8'hB0); push(1, 1'b1, 8'hB1);
    wait_acc(2);
    checks++;
    if (acc_id.size() < 2 || acc_id[0] != 1 || acc_id[1] != 0) begin
      failures++; $display("FAIL single_ptr_advance order=%0d,%0d want 1,0",
                           acc_id.size() > 0 ? acc_id[0] : -1, acc_id.size() > 1 ? acc_id[1] : -1);
    end
    wait_rx(2);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, 1'b1, 8'(8'h10 + i)); push(i, 1'b1, 8'(8'h10 + i));
    end
    wait_acc(8);
    checks++;
    if (acc_id.size() != 8) begin failures++; $display("FAIL rr_accept_count got=%0d want=8", acc_id.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++;
      if (acc_id[k] != k % 4 || acc_dat[k] != 'h10 + k % 4) begin
        failures++; $display("FAIL rr_order idx=%0d got id=%0d data=%h want id=%0d data=%h", k, acc_id[k], acc_dat[k], k % 4, 'h10 + k % 4);
      end
    end
    wait_rx(8);
    for (int k = 0; k < 8 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] != 'h10 + k % 4) begin failures++; $display("FAIL rr_tx idx=%0d got=%0d want=%0d", k, rx_q[k], 'h10 + k % 4); end
    end
  endtask

  task automatic test_locked();
    int exp_id[4]  = '{2, 2, 2, 1};
    int exp_dat[4] = '{'h01, 'h02, 'h03, 'h55};
    wait_idle(); clear_logs();
    push(1, 1'b1, 8'h21);
    wait_acc(1);
    wait_idle(); clear_logs();
    push(2, 1'b0, 8'h01); push(2, 1'b0, 8'h02); push(2, 1'b1, 8'h03);
    push(1, 1'b1, 8'h55);
    wait_acc(4);
    checks++;
    if (acc_id.size() != 4) begin failures++; $display("FAIL lock_accept_count got=%0d want=4", acc_id.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (acc_id[k] != exp_id[k] || acc_dat[k] != exp_dat[k]) begin
          failures++; $display("FAIL lock_order idx=%0d got id=%0d data=%h want id=%0d data=%h", k, acc_id[k], acc_dat[k], exp_id[k], exp_dat[k]);
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 43 || acc_cyc[2] - acc_cyc[1] != 43) begin
        failures++; $display("FAIL lock_gap got=%0d,%0d want=43,43", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
    wait_rx(4);
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] != exp_dat[k]) begin failures++; $display("FAIL lock_tx idx=%0d got=%0d want=%0d", k, rx_q[k], exp_dat[k]); end
    end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    push(0, 1'b0, 8'h77); push(3, 1'b1, 8'h33);
    wait_acc(1);
    t0 = acc_cyc.size() ? acc_cyc[0] : cyc;
    for (int k = 0; k < 200 && cyc < t0 + 47; k++) @(negedge clk);
    checks++;
    if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
      failures++; $display("FAIL hold_state gid=%0d busy=%0b req_ready=%b want 0 1 0000", bus.grant_id, bus.busy, bus.req_ready);
    end
    wait_acc(2);
    checks++;
    if (acc_id.size() != 2) begin failures++; $display("FAIL timeout_accept_count got=%0d want=2", acc_id.size()); end
    else begin
      checks++;
      if (acc_id[1] != 3 || acc_dat[1] != 'h33 || acc_cyc[1] - t0 != 51) begin
        failures++; $display("FAIL timeout_release got id=%0d data=%h gap=%0d want id=3 data=33 gap=51", acc_id[1], acc_dat[1], acc_cyc[1] - t0);
      end
    end
    wait_rx(2);
    checks++;
    if (rx_q.size() < 2 || rx_q[0] != 'h77 || rx_q[1] != 'h33) begin
      failures++; $display("FAIL timeout_tx got_count=%0d want 77,33", rx_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int t1;
    wait_idle(); clear_logs();
    push(1, 1'b1, 8'h5A);
    wait_acc(1);
    t1 = acc_cyc.size() ? acc_cyc[0] : cyc;
    for (int k = 0; k < 200 && cyc < t1 + 22; k++) @(negedge clk);
    push(2, 1'b1, 8'h99);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.send_valid !== 1'b0 || bus.data_bits !== 8'h00 || bus.grant_id !== 2'd0 ||
        bus.busy !== 1'b0 || bus.req_ready !== 4'b0) begin
      failures++; $display("FAIL midreset_outputs sv=%0b data=%h gid=%0d busy=%0b rr=%b want 0 00 0 0 0000",
                           bus.send_valid, bus.data_bits, bus.grant_id, bus.busy, bus.req_ready);
    end
    wait_acc(2);
    checks++;
    if (acc_id.size() != 2) begin failures++; $display("FAIL midreset_accept_count got=%0d want=2", acc_id.size()); end
    else begin
      checks++;
      if (acc_id[1] != 2 || acc_dat[1] != 'h99 || acc_cyc[1] - t1 != 42) begin
        failures++; $display("FAIL midreset_accept got id=%0d data=%h gap=%0d want id=2 data=99 gap=42", acc_id[1], acc_dat[1], acc_cyc[1] - t1);
      end
    end
    wait_rx(2);
    checks++;
    if (rx_q.size() < 2 || rx_q[0] != 'h5A || rx_q[1] != 'h99) begin
      failures++; $display("FAIL midreset_tx got_count=%0d first=%0d want 90,153", rx_q.size(), rx_q.size() ? rx_q[0] : -2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_locked();
    test_timeout();
    test_reset_midframe();
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
